bf_char_uart_bridge: RTL and testbench
======================================

// Module: bf_char_uart_bridge
// PURPOSE
//  Peer of the brainfuck core's parallel character interface.
//  Accepts '.' output pulses (sendingChar/sendedChar) into a TX FIFO and serialises them as UART 8N1.
//  Deserialises UART 8N1 input into single-cycle receivingChar/receivedChar pulses for ','.
//  Sits between brainfuckCore and the board UART pins.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 4
//  FIFO_AW       4    TX FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-low reset
//  out_valid     in   1  core sendingChar; each high cycle enqueues one byte
//  out_char      in   8  core sendedChar; sampled when out_valid=1
//  in_valid      out  1  to core receivingChar; one-cycle pulse per received byte
//  in_char       out  8  to core receivedChar; holds last good byte
//  uart_tx       out  1  serial out, idle high
//  uart_rx       in   1  serial in, asynchronous, idle high
//  tx_busy       out  1  1 while FIFO non-empty or a frame is on the line
//  tx_overflow   out  1  sticky: a byte was dropped because the FIFO was full
//  rx_frame_err  out  1  sticky: a stop bit was sampled low
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): uart_tx=1, in_valid=0, in_char=0, tx_busy=0, tx_overflow=0, rx_frame_err=0.
//   - FIFO emptied; both FSMs return to IDLE; RX synchroniser flops loaded with 1.
//   - Reset mid-frame truncates the frame: uart_tx is high from the first reset edge.
//  TX FIFO: synchronous, registered pointers plus count (FIFO_AW+1 bits).
//   - Push when out_valid=1 and not full. Push while full drops the byte and sets tx_overflow.
//   - Push and pop in the same cycle while full: push is accepted and count is unchanged.
//   - Pointers wrap modulo depth.
//  TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
//   - IDLE, FIFO non-empty: pop the head; uart_tx=0 from the next edge.
//   - Byte pushed into an empty idle FIFO at edge N: start bit drives from edge N+1.
//   - START: 1 bit time. DATA: 8 bits, LSB first, 1 bit time each. STOP: uart_tx=1 for 1 bit time.
//   - One bit time = CLKS_PER_BIT cycles, counted by a bit-timer that reloads at each bit boundary.
//   - From STOP, go to IDLE; the next frame may start on the following edge (no extra idle bit).
//   - tx_busy = (state != IDLE) | (count != 0), registered.
//  RX path: uart_rx passes through a 2-flop synchroniser before any use.
//  RX FSM, states IDLE -> START -> DATA -> STOP -> (IDLE | WAIT_HIGH):
//   - IDLE: a synchronised falling edge (1 -> 0) enters START.
//   - START: wait CLKS_PER_BIT/2 cycles and resample. Low: go to DATA. High: treat as a glitch, return to IDLE, no flags set.
//   - DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift into a register, LSB first; 8 samples.
//   - STOP: sample once after CLKS_PER_BIT.
//     High: in_char <= byte and in_valid=1 for exactly one cycle at that edge; go to IDLE.
//     Low: no pulse, in_char unchanged, set rx_frame_err, go to WAIT_HIGH.
//   - WAIT_HIGH: stay until the synchronised line is 1, then IDLE (a break does not retrigger).
//  RX and TX are fully independent; simultaneous activity is legal.
//  Sticky flags clear only on reset.
//  No backpressure toward the core: the core holds a ',' until in_valid. An in_valid pulse while the core is not waiting is lost, by design.
// TESTING (CLKS_PER_BIT=4, FIFO_AW=4 unless stated)
//  1 Reset with random inputs -> uart_tx=1, in_valid=0, in_char=0x00, tx_busy=0, both flags 0.
//  2 One out_valid pulse, out_char=0x41 -> from the next edge uart_tx = 0,1,0,0,0,0,0,1,0,1, 4 cycles each;
//    tx_busy falls after the stop bit.
//  3 18 back-to-back out_valid pulses, bytes 0x00..0x11 -> tx_overflow=1; 0x00..0x10 sent in order; 0x11 never sent.
//  4 Drive uart_rx with 8N1 frame 0x5A -> exactly one in_valid pulse, in_char=0x5A, rx_frame_err=0.
//  5 Frame 0x33 with stop bit low, line high after, then frame 0xC3 -> rx_frame_err=1;
//    no pulse for 0x33; one pulse with in_char=0xC3.
//  6 Reset asserted during TX data bit 3 while 3 bytes queued -> uart_tx=1 next edge, tx_busy=0;
//    no further frames after reset is released.

Source files
------------

// File: rtl/bf_char_uart_bridge.sv
// bf_char_uart_bridge
//   UART 8N1 bridge between the brainfuck core's parallel character interface
//   and the board serial pins. Core '.' output bytes are queued in a TX FIFO
//   and serialised on uart_tx. Bytes arriving on uart_rx are deserialised and
//   handed to the core as single-cycle in_valid pulses for ','.
//
// Ports
//   clk           clock
//   reset         synchronous, active-low reset
//   out_valid     core sendingChar; each high cycle enqueues out_char
//   out_char      core sendedChar (8 bits)
//   in_valid      core receivingChar; one-cycle pulse per good received byte
//   in_char       core receivedChar; holds last good byte
//   uart_tx       serial out, idle high
//   uart_rx       serial in, asynchronous, idle high
//   tx_busy       FIFO non-empty or a frame on the line
//   tx_overflow   sticky: a byte was dropped because the FIFO was full
//   rx_frame_err  sticky: a stop bit was sampled low

module bf_char_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_valid,
  input  logic [7:0] out_char,
  output logic       in_valid,
  output logic [7:0] in_char,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rx_frame_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;

  logic      fifo_full_c;
  logic      fifo_empty_c;
  logic      pop_c;
  logic      push_c;
  tx_state_t tx_state;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still
  // accepted when the TX FSM is draining the head.
  always_comb begin
    fifo_full_c  = (count == CW'(DEPTH));
    fifo_empty_c = (count == '0);
    pop_c        = (tx_state == TX_IDLE) && !fifo_empty_c;
    push_c       = out_valid && (!fifo_full_c || pop_c);
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      mem[wr_ptr] <= out_char;
    end
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (out_valid && !push_c) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX serialiser
  // ---------------------------------------------------------------------------
  logic [BW-1:0] tx_timer;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_bit_idx;

  // Each state holds its line level for one bit time; the timer reloads at
  // every bit boundary. tx_busy is a registered copy of the activity term.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_timer   <= '0;
      tx_shift   <= '0;
      tx_bit_idx <= '0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      tx_busy <= (tx_state != TX_IDLE) || !fifo_empty_c;
      case (tx_state)
        TX_IDLE: begin
          if (pop_c) begin
            tx_shift <= mem[rd_ptr];
            tx_timer <= BIT_LAST;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_timer == '0) begin
            tx_timer   <= BIT_LAST;
            tx_bit_idx <= '0;
            uart_tx    <= tx_shift[0];
            tx_state   <= TX_DATA;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == '0) begin
            tx_timer <= BIT_LAST;
            if (tx_bit_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift   <= {1'b0, tx_shift[7:1]};
              uart_tx    <= tx_shift[1];
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == '0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Two flops for metastability, a third to detect the falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // RX deserialiser
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state;
  logic [BW-1:0] rx_timer;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_bit_idx;

  // Half a bit after the falling edge re-checks the start bit, then every
  // full bit time lands mid-bit. A low stop bit parks in WAIT_HIGH so a held
  // break cannot look like a fresh start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state     <= RX_IDLE;
      rx_timer     <= '0;
      rx_shift     <= '0;
      rx_bit_idx   <= '0;
      in_valid     <= 1'b0;
      in_char      <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      in_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_timer <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_timer == '0) begin
            if (!rx_sync) begin
              rx_timer   <= BIT_LAST;
              rx_bit_idx <= '0;
              rx_state   <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_timer == '0) begin
            rx_timer <= BIT_LAST;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit_idx <= rx_bit_idx + 1'b1;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_timer == '0) begin
            if (rx_sync) begin
              in_char  <= rx_shift;
              in_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_char_uart_bridge.sv
// tb_bf_char_uart_bridge
//   Directed bench for bf_char_uart_bridge with CLKS_PER_BIT=4, FIFO_AW=4.
//   A serial monitor decodes uart_tx into a byte queue; the stimulus block
//   drives the core side and uart_rx and compares against hand-computed values.

module tb_bf_char_uart_bridge;

  localparam int unsigned CPB = 4;
  localparam int unsigned FAW = 4;

  logic       clk;
  logic       reset;
  logic       out_valid;
  logic [7:0] out_char;
  logic       in_valid;
  logic [7:0] in_char;
  logic       uart_tx;
  logic       uart_rx;
  logic       tx_busy;
  logic       tx_overflow;
  logic       rx_frame_err;

  int         checks = 0;
  int         failures = 0;
  int         rx_pulses = 0;
  logic [7:0] rx_last = 8'h00;
  logic [9:0] frame;

  logic [7:0] mon_q[$];
  logic [7:0] mon_b;
  int         mon_stop_err = 0;

  bf_char_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (FAW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .out_valid   (out_valid),
    .out_char    (out_char),
    .in_valid    (in_valid),
    .in_char     (in_char),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .rx_frame_err(rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; sample 1 time unit after the edge and count in_valid pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (in_valid === 1'b1) begin
      rx_pulses = rx_pulses + 1;
      rx_last   = in_char;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame on uart_rx, CPB cycles per bit.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
  endtask

  // Serial monitor on uart_tx, sampling mid-bit on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          mon_b[k] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) mon_stop_err = mon_stop_err + 1;
        mon_q.push_back(mon_b);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    uart_rx   = 1'b1;

    // 1: reset with random inputs
    for (int i = 0; i < 5; i++) begin
      out_valid = 1'($urandom_range(1, 0));
      out_char  = 8'($urandom);
      uart_rx   = 1'($urandom_range(1, 0));
      tick();
    end
    out_valid = 1'b0;
    uart_rx   = 1'b1;
    repeat (3) tick();
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_in_char", 32'(in_char), 32'h00);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 32'd0);
    reset = 1'b1;
    repeat (4) tick();
    mon_q.delete();

    // 2: single byte 0x41, bit-exact line waveform
    out_valid = 1'b1;
    out_char  = 8'h41;
    tick();
    out_valid = 1'b0;
    frame = {1'b1, 8'h41, 1'b0};
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("t2_tx_cyc%0d", i), 32'(uart_tx), 32'(frame[i / 4]));
    end
    check("t2_busy_in_stop", 32'(tx_busy), 32'd1);
    repeat (2) tick();
    check("t2_busy_after", 32'(tx_busy), 32'd0);
    check("t2_tx_idle", 32'(uart_tx), 32'd1);
    check("t2_no_overflow", 32'(tx_overflow), 32'd0);

    // 3: 18 back-to-back bytes, last one dropped
    mon_q.delete();
    for (int b = 0; b < 18; b++) begin
      out_valid = 1'b1;
      out_char  = 8'(b);
      tick();
    end
    out_valid = 1'b0;
    check("t3_overflow", 32'(tx_overflow), 32'd1);
    for (int k = 0; k < 1500 && mon_q.size() < 17; k++) tick();
    repeat (120) tick();
    check("t3_frame_count", 32'(mon_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < mon_q.size(); i++) begin
      check($sformatf("t3_byte%0d", i), 32'(mon_q[i]), 32'(i));
    end
    check("t3_stop_bits", 32'(mon_stop_err), 32'd0);
    check("t3_busy_done", 32'(tx_busy), 32'd0);

    // 4: receive 0x5A
    rx_pulses = 0;
    send_rx(8'h5A, 1'b1);
    repeat (8) tick();
    check("t4_pulses", 32'(rx_pulses), 32'd1);
    check("t4_pulse_char", 32'(rx_last), 32'h5A);
    check("t4_in_char", 32'(in_char), 32'h5A);
    check("t4_frame_err", 32'(rx_frame_err), 32'd0);

    // one-cycle low glitch is rejected silently
    rx_pulses = 0;
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    check("glitch_pulses", 32'(rx_pulses), 32'd0);
    check("glitch_frame_err", 32'(rx_frame_err), 32'd0);
    check("glitch_in_char", 32'(in_char), 32'h5A);

    // 5: bad stop bit on 0x33, then good 0xC3
    rx_pulses = 0;
    send_rx(8'h33, 1'b0);
    repeat (8) tick();
    check("t5_bad_pulses", 32'(rx_pulses), 32'd0);
    check("t5_frame_err", 32'(rx_frame_err), 32'd1);
    check("t5_char_held", 32'(in_char), 32'h5A);
    send_rx(8'hC3, 1'b1);
    repeat (8) tick();
    check("t5_good_pulses", 32'(rx_pulses), 32'd1);
    check("t5_pulse_char", 32'(rx_last), 32'hC3);
    check("t5_in_char", 32'(in_char), 32'hC3);
    check("t5_err_sticky", 32'(rx_frame_err), 32'd1);

    // 6: reset during data bit 3 of 0xA5 with 3 more bytes queued
    mon_q.delete();
    out_char = 8'hA5; out_valid = 1'b1; tick();
    out_char = 8'h3C; tick();
    out_char = 8'h96; tick();
    out_char = 8'h0F; tick();
    out_valid = 1'b0;
    repeat (15) tick();
    check("t6_pre_bit3", 32'(uart_tx), 32'd0);
    check("t6_pre_busy", 32'(tx_busy), 32'd1);
    reset = 1'b0;
    tick();
    check("t6_rst_tx", 32'(uart_tx), 32'd1);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    check("t6_rst_err_clr", 32'(rx_frame_err), 32'd0);
    tick();
    reset = 1'b1;
    repeat (60) tick();
    mon_q.delete();
    repeat (200) tick();
    check("t6_no_frames", 32'(mon_q.size()), 32'd0);
    check("t6_tx_idle", 32'(uart_tx), 32'd1);
    check("t6_busy_idle", 32'(tx_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
